mbt_pixel_scheduler: RTL and testbench

- Sequences one Mandelbrot frame across NUM_LANES escape-time ALU instances. Each instance is a 16-bit Q4.11 fixed-point core with active-high sync rst, start, c_real, c_img, valid and 7-bit d_out.
- Generates pixel coordinates in raster order, dispatches each coordinate to a free lane, and collects the iteration counts.
- Streams (address, iteration) pairs to the frame-buffer writer over a valid/ready handshake.
- Sits between the display/zoom control logic and the ALU array.

---
 rtl/mbt_pixel_scheduler_pkg.sv | 15 +
 rtl/mbt_pixel_scheduler_lane.sv | 116 +++++++++++
 rtl/mbt_pixel_scheduler.sv | 200 ++++++++++++++++++++
 tb/tb_mbt_pixel_scheduler.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mbt_pixel_scheduler_pkg.sv
// Shared constants and state encodings for the Mandelbrot pixel scheduler.
// Coordinates are Q4.11 (16 bit), iteration counts are 7 bit.
package mbt_pkg;
  localparam int FXP_W = 16;
  localparam int ITER_W = 7;
  localparam logic [ITER_W-1:0] TIMEOUT_ITER = 7'd127;

  typedef enum logic [1:0] {T_IDLE, T_RUN, T_DRAIN, T_DONE} top_state_t;
  typedef enum logic [2:0] {L_FREE, L_CLR, L_GO, L_BUSY, L_DONE} lane_state_t;

  typedef struct packed {
    logic [FXP_W-1:0] re;
    logic [FXP_W-1:0] im;
  } coord_t;
endpackage

// File: rtl/mbt_pixel_scheduler_lane.sv
// One ALU lane: clear, start, wait for result, hold it until collected (MBT_SCHED_TIMEOUT_EN adds a watchdog).
// Latency: dispatch -> ALU start is 2 cycles; result captured the edge after alu_valid.
// Backpressure: a finished lane parks in DONE until the collector takes its result.
module mbt_sched_lane
  import mbt_pkg::*;
#(
  parameter int ADDR_W = 17
`ifdef MBT_SCHED_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 300
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              abort,
  input  logic              dispatch,
  input  logic              collect,
  input  logic [FXP_W-1:0]  c_real,
  input  logic [FXP_W-1:0]  c_img,
  input  logic [ADDR_W-1:0] addr,
  input  logic              alu_valid,
  input  logic [ITER_W-1:0] alu_iter,
  output logic              alu_rst,
  output logic              alu_start,
  output logic [FXP_W-1:0]  alu_c_real,
  output logic [FXP_W-1:0]  alu_c_img,
  output logic              lane_free,
  output logic              lane_done,
  output logic [ADDR_W-1:0] lane_addr,
  output logic [ITER_W-1:0] lane_iter
`ifdef MBT_SCHED_TIMEOUT_EN
  ,
  input  logic              frame_go,
  output logic              timeout_flag
`endif
);
  lane_state_t state;
  coord_t      coord_q;
  logic        wd_hit;

`ifdef MBT_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] wd_cnt;

  assign wd_hit = (state == L_BUSY) && (wd_cnt == CW'(TIMEOUT_CYC - 1)) && !alu_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt       <= '0;
      timeout_flag <= 1'b0;
    end else begin
      if (state == L_BUSY && !abort) wd_cnt <= wd_cnt + 1'b1;
      else                           wd_cnt <= '0;
      if (frame_go)                  timeout_flag <= 1'b0;
      else if (wd_hit && !abort)     timeout_flag <= 1'b1;
    end
  end
`else
  assign wd_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= L_FREE;
      alu_rst   <= 1'b1;
      alu_start <= 1'b0;
      coord_q   <= '0;
      lane_addr <= '0;
      lane_iter <= '0;
    end else if (abort) begin
      state     <= L_FREE;
      alu_rst   <= 1'b1;
      alu_start <= 1'b0;
    end else begin
      case (state)
        L_FREE: if (dispatch) begin
          state      <= L_CLR;
          coord_q.re <= c_real;
          coord_q.im <= c_img;
          lane_addr  <= addr;
        end
        L_CLR: begin
          state     <= L_GO;
          alu_rst   <= 1'b0;
          alu_start <= 1'b1;
        end
        L_GO: begin
          state     <= L_BUSY;
          alu_start <= 1'b0;
        end
        L_BUSY: if (alu_valid) begin
          state     <= L_DONE;
          lane_iter <= alu_iter;
        end else if (wd_hit) begin
          state     <= L_DONE;
          lane_iter <= TIMEOUT_ITER;
        end
        L_DONE: if (collect) begin
          // back to FREE with the ALU held in reset so its valid drops
          state   <= L_FREE;
          alu_rst <= 1'b1;
        end
        default: begin
          state     <= L_FREE;
          alu_rst   <= 1'b1;
          alu_start <= 1'b0;
        end
      endcase
    end
  end

  assign alu_c_real = coord_q.re;
  assign alu_c_img  = coord_q.im;
  assign lane_free  = (state == L_FREE);
  assign lane_done  = (state == L_DONE);
endmodule

// File: rtl/mbt_pixel_scheduler.sv
// Raster-order Mandelbrot frame sequencer over NUM_LANES ALUs; MBT_SCHED_TIMEOUT_EN adds lane watchdogs + sticky_timeout.
// Latency: one dispatch per cycle; a result reaches the output register one cycle after its lane enters DONE.
// Backpressure: pix_ready low holds the output register; lanes then stall in DONE and dispatch stops.
module mbt_pixel_scheduler
  import mbt_pkg::*;
#(
  parameter int NUM_LANES   = 4,
  parameter int H_RES       = 320,
  parameter int V_RES       = 240,
  parameter int ADDR_W      = 17,
  parameter int TIMEOUT_CYC = 300
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       frame_start,
  input  logic                       abort,
  input  logic [FXP_W-1:0]           x_min,
  input  logic [FXP_W-1:0]           y_min,
  input  logic [FXP_W-1:0]           step,
  output logic                       busy,
  output logic                       frame_done,
  output logic [NUM_LANES-1:0]       alu_rst,
  output logic [NUM_LANES-1:0]       alu_start,
  output logic [FXP_W*NUM_LANES-1:0] alu_c_real,
  output logic [FXP_W*NUM_LANES-1:0] alu_c_img,
  input  logic [NUM_LANES-1:0]       alu_valid,
  input  logic [ITER_W*NUM_LANES-1:0] alu_iter,
  output logic                       pix_valid,
  input  logic                       pix_ready,
  output logic [ADDR_W-1:0]          pix_addr,
  output logic [ITER_W-1:0]          pix_iter
`ifdef MBT_SCHED_TIMEOUT_EN
  ,
  output logic [NUM_LANES-1:0]       sticky_timeout
`endif
);
  localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int XW = $clog2(H_RES + 1);
  localparam int YW = $clog2(V_RES + 1);

  if (NUM_LANES < 1 || NUM_LANES > 8 || TIMEOUT_CYC < 1 ||
      (64'd1 << ADDR_W) < 64'(H_RES * V_RES)) begin : g_bad_params
    $error("mbt_pixel_scheduler: illegal parameter combination");
  end

  top_state_t        state;
  logic [FXP_W-1:0]  x_min_q, step_q, cr, ci;
  logic [XW-1:0]     x_cnt;
  logic [YW-1:0]     y_cnt;
  logic [ADDR_W-1:0] addr_cnt;

  logic [NUM_LANES-1:0] lane_free, lane_done, dispatch, collect;
  logic [ADDR_W-1:0]    lane_addr [NUM_LANES];
  logic [ITER_W-1:0]    lane_iter [NUM_LANES];

  logic          disp_vld, grant_vld, hi_vld, lo_vld;
  logic [LW-1:0] disp_idx, grant_idx, hi_idx, lo_idx, last_grant;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    mbt_sched_lane #(
      .ADDR_W(ADDR_W)
`ifdef MBT_SCHED_TIMEOUT_EN
      ,
      .TIMEOUT_CYC(TIMEOUT_CYC)
`endif
    ) u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .abort      (abort),
      .dispatch   (dispatch[g]),
      .collect    (collect[g]),
      .c_real     (cr),
      .c_img      (ci),
      .addr       (addr_cnt),
      .alu_valid  (alu_valid[g]),
      .alu_iter   (alu_iter[ITER_W*g +: ITER_W]),
      .alu_rst    (alu_rst[g]),
      .alu_start  (alu_start[g]),
      .alu_c_real (alu_c_real[FXP_W*g +: FXP_W]),
      .alu_c_img  (alu_c_img[FXP_W*g +: FXP_W]),
      .lane_free  (lane_free[g]),
      .lane_done  (lane_done[g]),
      .lane_addr  (lane_addr[g]),
      .lane_iter  (lane_iter[g])
`ifdef MBT_SCHED_TIMEOUT_EN
      ,
      .frame_go     (frame_start && state == T_IDLE && !abort),
      .timeout_flag (sticky_timeout[g])
`endif
    );
  end

  // lowest-index FREE lane; a lane freed this cycle still reads DONE here
  always_comb begin
    disp_vld = 1'b0;
    disp_idx = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (lane_free[i]) begin
        disp_vld = 1'b1;
        disp_idx = LW'(i);
      end
    end
    if (state != T_RUN || abort) disp_vld = 1'b0;
  end

  // round-robin: first DONE lane above last_grant, else wrap to the lowest
  always_comb begin
    hi_vld = 1'b0;
    hi_idx = '0;
    lo_vld = 1'b0;
    lo_idx = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (lane_done[i]) begin
        lo_vld = 1'b1;
        lo_idx = LW'(i);
        if (i > int'(last_grant)) begin
          hi_vld = 1'b1;
          hi_idx = LW'(i);
        end
      end
    end
    grant_vld = (hi_vld || lo_vld) && (!pix_valid || pix_ready) && !abort;
    grant_idx = hi_vld ? hi_idx : lo_idx;
  end

  assign dispatch = disp_vld  ? (NUM_LANES'(1) << disp_idx)  : '0;
  assign collect  = grant_vld ? (NUM_LANES'(1) << grant_idx) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= T_IDLE;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      x_min_q    <= '0;
      step_q     <= '0;
      cr         <= '0;
      ci         <= '0;
      x_cnt      <= '0;
      y_cnt      <= '0;
      addr_cnt   <= '0;
    end else if (abort) begin
      state      <= T_IDLE;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        T_IDLE: if (frame_start) begin
          state    <= T_RUN;
          busy     <= 1'b1;
          x_min_q  <= x_min;
          step_q   <= step;
          cr       <= x_min;
          ci       <= y_min;
          x_cnt    <= '0;
          y_cnt    <= '0;
          addr_cnt <= '0;
        end
        T_RUN: if (disp_vld) begin
          addr_cnt <= addr_cnt + 1'b1;
          if (x_cnt == XW'(H_RES - 1)) begin
            x_cnt <= '0;
            cr    <= x_min_q;
            y_cnt <= y_cnt + 1'b1;
            ci    <= ci + step_q;
            if (y_cnt == YW'(V_RES - 1)) state <= T_DRAIN;
          end else begin
            x_cnt <= x_cnt + 1'b1;
            cr    <= cr + step_q;
          end
        end
        T_DRAIN: if (&lane_free && !pix_valid) begin
          state      <= T_DONE;
          busy       <= 1'b0;
          frame_done <= 1'b1;
        end
        T_DONE:  state <= T_IDLE;
        default: state <= T_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_valid  <= 1'b0;
      pix_addr   <= '0;
      pix_iter   <= '0;
      last_grant <= '0;
    end else if (abort) begin
      pix_valid <= 1'b0;
    end else if (grant_vld) begin
      pix_valid  <= 1'b1;
      pix_addr   <= lane_addr[grant_idx];
      pix_iter   <= lane_iter[grant_idx];
      last_grant <= grant_idx;
    end else if (pix_ready) begin
      pix_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mbt_pixel_scheduler.sv
// Directed bench for mbt_pixel_scheduler on a 4x2 frame with two modelled ALU lanes.
// Frame scenarios come from a vector table; abort and watchdog cases are hand sequences.
module tb_mbt_pixel_scheduler;
  localparam int NL = 2, HR = 4, VR = 2, AW = 3, NPIX = HR * VR;

  logic clk = 1'b0, rst_n = 1'b0, frame_start = 1'b0, abort = 1'b0, pix_ready = 1'b1;
  logic [15:0] x_min = '0, y_min = '0, step = '0;
  logic busy, frame_done, pix_valid;
  logic [NL-1:0] alu_rst, alu_start;
  logic [NL-1:0] alu_valid = '0;
  logic [16*NL-1:0] alu_c_real, alu_c_img;
  logic [7*NL-1:0] alu_iter = '0;
  logic [AW-1:0] pix_addr;
  logic [6:0] pix_iter;
`ifdef MBT_SCHED_TIMEOUT_EN
  logic [NL-1:0] sticky_timeout;
`endif

  mbt_pixel_scheduler #(.NUM_LANES(NL), .H_RES(HR), .V_RES(VR), .ADDR_W(AW), .TIMEOUT_CYC(10)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .abort(abort),
    .x_min(x_min), .y_min(y_min), .step(step), .busy(busy), .frame_done(frame_done),
    .alu_rst(alu_rst), .alu_start(alu_start), .alu_c_real(alu_c_real), .alu_c_img(alu_c_img),
    .alu_valid(alu_valid), .alu_iter(alu_iter), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_addr(pix_addr), .pix_iter(pix_iter)
`ifdef MBT_SCHED_TIMEOUT_EN
    , .sticky_timeout(sticky_timeout)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // frame-level model state shared between the stimulus task and the monitors
  logic [15:0] m_xm = '0, m_ym = '0, m_st = 16'd1;
  int lat [NL];
  logic hang [NL];
  int acnt [NL];
  logic arun [NL];
  int n_disp, n_acc, fd_cnt, starts, max_addr, busy_at_fd, busy_prev_fd;
  int acc_cnt [NPIX];
  logic exp127 [NPIX];
  logic ooo;
  logic [15:0] cr_log [NPIX], ci_log [NPIX];
  logic [15:0] lane_cr [NL], lane_ci [NL];

  function automatic int c2addr(input logic [15:0] cr, input logic [15:0] ci);
    logic [15:0] dx, dy;
    dx = cr - m_xm;
    dy = ci - m_ym;
    return int'(dx / m_st) + HR * int'(dy / m_st);
  endfunction

  // behavioural ALU: valid rises lat cycles after start, iter = pixel address
  always @(posedge clk) begin
    for (int i = 0; i < NL; i++) begin
      if (alu_rst[i]) begin
        alu_valid[i] <= 1'b0;
        arun[i] <= 1'b0;
        acnt[i] <= 0;
      end else if (alu_start[i]) begin
        arun[i] <= 1'b1;
        acnt[i] <= lat[i] - 1;
        alu_iter[7*i +: 7] <= 7'(c2addr(alu_c_real[16*i +: 16], alu_c_img[16*i +: 16]));
      end else if (arun[i]) begin
        if (acnt[i] > 0) acnt[i] <= acnt[i] - 1;
        else if (!hang[i]) alu_valid[i] <= 1'b1;
      end
    end
  end

  logic [NL-1:0] prev_rst = '1, prev_start = '0;
  logic prev_busy = 1'b0, prev_pv = 1'b0, prev_pr = 1'b1;
  logic [AW-1:0] prev_addr = '0;
  logic [6:0] prev_iter = '0;

  always @(negedge clk) begin : mon
    logic [15:0] cr, ci;
    int a;
    if (rst_n) begin
      for (int i = 0; i < NL; i++) begin
        if (prev_start[i]) check("go_one_cycle", alu_start[i], 0);
        if (alu_start[i]) begin
          cr = alu_c_real[16*i +: 16];
          ci = alu_c_img[16*i +: 16];
          check("clr_then_go", {prev_rst[i], alu_rst[i]}, 2'b10);
          check("disp_c_real", cr, m_xm + m_st * 16'(n_disp % HR));
          check("disp_c_img", ci, m_ym + m_st * 16'(n_disp / HR));
          if (n_disp < NPIX) begin
            cr_log[n_disp] = cr;
            ci_log[n_disp] = ci;
          end
          a = c2addr(cr, ci);
          if (hang[i] && a >= 0 && a < NPIX) exp127[a] = 1'b1;
          lane_cr[i] = cr;
          lane_ci[i] = ci;
          n_disp++;
          starts++;
        end else if (!alu_rst[i]) begin
          check("coord_hold", {alu_c_real[16*i +: 16], alu_c_img[16*i +: 16]}, {lane_cr[i], lane_ci[i]});
        end
      end
      if (prev_pv && !prev_pr) begin
        check("hold_valid", pix_valid, 1);
        check("hold_addr", pix_addr, prev_addr);
        check("hold_iter", pix_iter, prev_iter);
      end
      if (pix_valid && pix_ready) begin
        a = int'(pix_addr);
        acc_cnt[a]++;
        check("pix_iter", pix_iter, exp127[a] ? 32'd127 : 32'(a));
        if (a < max_addr) ooo = 1'b1;
        if (a > max_addr) max_addr = a;
        n_acc++;
      end
      if (frame_done) begin
        fd_cnt++;
        busy_at_fd = int'(busy);
        busy_prev_fd = int'(prev_busy);
      end
    end
    prev_rst = alu_rst;
    prev_start = alu_start;
    prev_busy = busy;
    prev_pv = pix_valid;
    prev_pr = pix_ready;
    prev_addr = pix_addr;
    prev_iter = pix_iter;
  end

  typedef struct {
    logic [15:0] xm, ym, st;
    int lat0, lat1;
    logic hang1;
    int stall_at, stall_len;
    logic mid_start;
    logic exp_ooo;
  } fvec_t;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input fvec_t v);
    int cyc, s0;
    bit stalled;
    lat[0] = v.lat0; lat[1] = v.lat1;
    hang[0] = 1'b0; hang[1] = v.hang1;
    m_xm = v.xm; m_ym = v.ym; m_st = v.st;
    n_disp = 0; n_acc = 0; fd_cnt = 0; starts = 0; max_addr = -1; ooo = 1'b0;
    for (int a = 0; a < NPIX; a++) begin
      acc_cnt[a] = 0;
      exp127[a] = 1'b0;
    end
    x_min = v.xm; y_min = v.ym; step = v.st; pix_ready = 1'b1;
    frame_start = 1'b1;
    cycle();
    frame_start = 1'b0;
    check("busy_after_start", busy, 1);
    cyc = 0;
    stalled = 0;
    while (fd_cnt == 0 && cyc < 2000) begin
      if (v.stall_len > 15 && !stalled && n_acc >= v.stall_at) begin
        stalled = 1;
        pix_ready = 1'b0;
        repeat (15) cycle();
        s0 = starts;
        repeat (v.stall_len - 15) cycle();
        check("stall_no_dispatch", starts - s0, 0);
        check("stall_lanes_done", alu_rst, 0);
        check("stall_valid", pix_valid, 1);
        pix_ready = 1'b1;
      end
      if (v.mid_start && cyc == 5) begin
        frame_start = 1'b1;
        x_min = 16'h4000; y_min = 16'h4000; step = 16'h0100;
      end else begin
        frame_start = 1'b0;
      end
      cycle();
      cyc++;
    end
    frame_start = 1'b0;
    check("frame_done_in_time", cyc < 2000, 1);
    repeat (5) cycle();
    check("frame_done_pulses", fd_cnt, 1);
    check("busy_low_at_done", busy_at_fd, 0);
    check("busy_high_before_done", busy_prev_fd, 1);
    check("pixels_out", n_acc, NPIX);
    check("dispatches", n_disp, NPIX);
    for (int a = 0; a < NPIX; a++) check("addr_once", acc_cnt[a], 1);
    if (v.exp_ooo) check("out_of_order", ooo, 1);
  endtask

  fvec_t vec [4];
  fvec_t tv;
  logic [15:0] exp_cr [5];

  initial begin
    // xm, ym, step, lat0, lat1, hang1, stall_at, stall_len, mid_start, exp_ooo
    vec[0] = '{16'hF800, 16'hFB50, 16'h0008, 5, 5, 1'b0, 0, 0, 1'b0, 1'b0};
    vec[1] = '{16'h0000, 16'h0000, 16'h0010, 5, 5, 1'b0, 3, 20, 1'b0, 1'b0};
    vec[2] = '{16'h7FF0, 16'h7FF8, 16'h0008, 3, 9, 1'b0, 0, 0, 1'b0, 1'b1};
    vec[3] = '{16'h1000, 16'hF000, 16'h0020, 9, 3, 1'b0, 0, 0, 1'b1, 1'b1};
    exp_cr = '{16'hF800, 16'hF808, 16'hF810, 16'hF818, 16'hF800};
    for (int i = 0; i < NL; i++) begin
      lat[i] = 5;
      hang[i] = 1'b0;
    end

    #12;
    check("rst_alu_rst", alu_rst, 2'b11);
    check("rst_alu_start", alu_start, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_pix_valid", pix_valid, 0);
    check("rst_pix_addr", pix_addr, 0);
    check("rst_pix_iter", pix_iter, 0);
    check("rst_c_real", alu_c_real, 0);
    check("rst_c_img", alu_c_img, 0);
`ifdef MBT_SCHED_TIMEOUT_EN
    check("rst_sticky", sticky_timeout, 0);
`endif
    #10 rst_n = 1'b1;
    cycle();

    for (int v = 0; v < 4; v++) begin
      run_frame(vec[v]);
      if (v == 0) begin
        for (int k = 0; k < 5; k++) check("cr_sequence", cr_log[k], exp_cr[k]);
        check("ci_row0", ci_log[3], 16'hFB50);
        check("ci_row1", ci_log[4], 16'hFB58);
      end
    end

    // abort with both lanes busy, then abort against a same-cycle frame_start
    lat[0] = 30; lat[1] = 30;
    m_xm = 16'h0000; m_ym = 16'h0000; m_st = 16'h0008;
    x_min = m_xm; y_min = m_ym; step = m_st; n_disp = 0;
    frame_start = 1'b1;
    cycle();
    frame_start = 1'b0;
    repeat (7) cycle();
    check("abort_pre_lanes_busy", alu_rst, 2'b00);
    fd_cnt = 0;
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    check("abort_alu_rst", alu_rst, 2'b11);
    check("abort_pix_valid", pix_valid, 0);
    check("abort_busy", busy, 0);
    repeat (20) cycle();
    check("abort_no_frame_done", fd_cnt, 0);
    abort = 1'b1;
    frame_start = 1'b1;
    cycle();
    abort = 1'b0;
    frame_start = 1'b0;
    check("abort_beats_start", busy, 0);
    cycle();
    check("abort_start_ignored", alu_rst, 2'b11);
    run_frame(vec[0]);

`ifdef MBT_SCHED_TIMEOUT_EN
    tv = '{16'h0000, 16'h0000, 16'h0008, 5, 5, 1'b1, 0, 0, 1'b0, 1'b0};
    run_frame(tv);
    check("sticky_timeout_set", sticky_timeout, 2'b10);
    run_frame(vec[0]);
    check("sticky_timeout_cleared", sticky_timeout, 2'b00);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
